// File: rtl/wb_data_ram_slave.sv
// Wishbone-style data RAM responder for the CPU data bus.
// Accepts single read/write cycles, inserts WAIT_STATES wait cycles, then
// returns a one-cycle registered ack, or err for an illegal address.
module wb_data_ram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int unsigned Words = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StWait, StAck, StErr} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [3:0]              sel_q;
    logic [31:0]             dat_q;
    logic                    ack_q;
    logic                    err_q;
    logic [31:0]             rdata_q;
    logic [31:0]             mem_q [Words];

    logic                    req;
    logic [30:0]             off_w;
    logic                    adr_legal;
    logic [ADDR_WIDTH-1:0]   idx_in;

    logic                    commit;
    logic                    c_we;
    logic [ADDR_WIDTH-1:0]   c_idx;
    logic [3:0]              c_sel;
    logic [31:0]             c_dat;

    assign req = wb_cyc_i & wb_stb_i;

    // Word offset from the base; bit 30 set means the address is below the base.
    assign off_w     = {1'b0, wb_adr_i[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign adr_legal = (wb_adr_i[1:0] == 2'b00) && !off_w[30] &&
                       (off_w[29:ADDR_WIDTH] == '0);
    assign idx_in    = off_w[ADDR_WIDTH-1:0];

    // Transfer commits on the edge entering ACK; with no wait states the live
    // request is used directly since nothing has been latched yet.
    always_comb begin
        commit = 1'b0;
        c_we   = we_q;
        c_idx  = idx_q;
        c_sel  = sel_q;
        c_dat  = dat_q;
        if (state_q == StIdle && req && adr_legal && WAIT_STATES == 0) begin
            commit = 1'b1;
            c_we   = wb_we_i;
            c_idx  = idx_in;
            c_sel  = wb_sel_i;
            c_dat  = wb_dat_i;
        end else if (state_q == StWait && wb_cyc_i && cnt_q == 4'd0) begin
            commit = 1'b1;
        end
    end

    // Bus FSM with registered ack/err/read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        we_q  <= wb_we_i;
                        idx_q <= idx_in;
                        sel_q <= wb_sel_i;
                        dat_q <= wb_dat_i;
                        if (!adr_legal) begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state_q <= StAck;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                StWait: begin
                    if (!wb_cyc_i) begin
                        state_q <= StIdle;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= StAck;
                        ack_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StAck:   state_q <= StIdle;
                StErr:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (commit && !c_we) begin
                rdata_q <= mem_q[c_idx];
            end
        end
    end

    // Byte-lane memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && commit && c_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_sel[i]) begin
                    mem_q[c_idx][8*i +: 8] <= c_dat[8*i +: 8];
                end
            end
        end
    end

    assign wb_dat_o = rdata_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// Scoreboard bench for wb_data_ram_slave: three instances with 0, 1 and 3
// wait states (the last with a non-zero base) share one clock and reset.
module tb_wb_data_ram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc [3];
    logic        stb [3];
    logic        we [3];
    logic [31:0] adr [3];
    logic [3:0]  sel [3];
    logic [31:0] wdat [3];
    logic [31:0] rdat [3];
    logic        ack [3];
    logic        err [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_data_ram_slave #(
            .ADDR_WIDTH (10),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3)),
            .BASE_ADDR  (g == 2 ? 32'h0000_2000 : 32'h0000_0000)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .wb_cyc_i(cyc[g]),
            .wb_stb_i(stb[g]),
            .wb_we_i (we[g]),
            .wb_adr_i(adr[g]),
            .wb_sel_i(sel[g]),
            .wb_dat_i(wdat[g]),
            .wb_dat_o(rdat[g]),
            .wb_ack_o(ack[g]),
            .wb_err_o(err[g])
        );
    end

    typedef struct {
        int          k;
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl [3][1024];
    bit          known [3][1024];
    logic [31:0] last_rd [3];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] base_of(int k);
        return (k == 2) ? 32'h0000_2000 : 32'h0000_0000;
    endfunction

    function automatic int ws_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic bit legal(int k, logic [31:0] a);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(base_of(k));
        return (a[1:0] == 2'b00) && (ua >= ub) && (ua < ub + 4096);
    endfunction

    // Monitor: every ack/err must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ack[k] && err[k]) chk("ack_and_err", 32'd1, 32'd0);
            if (ack[k] || err[k]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", {31'd0, ack[k] | err[k]}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_inst", k, e.k);
                    chk("resp_is_err", {31'd0, err[k]}, {31'd0, e.is_err});
                    chk("resp_data", rdat[k], e.data);
                end
            end
        end
    end

    // One transfer; hold keeps cyc/stb asserted after the response.
    task automatic xfer(input int k, input bit w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d, input bit hold);
        exp_t e;
        int   n;
        bit   got;
        bit   ok;
        int   idx;
        ok  = legal(k, a);
        idx = int'((a - base_of(k)) >> 2);
        e.k = k;
        e.is_err = !ok;
        e.data = last_rd[k];
        if (ok && w) begin
            for (int i = 0; i < 4; i++) if (s[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
        end else if (ok) begin
            e.data     = mdl[k][idx];
            last_rd[k] = mdl[k][idx];
        end
        sb.push_back(e);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; wdat[k] = d;
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk); #1;
            n++;
            if (ack[k] || err[k]) got = 1'b1;
        end
        if (!got) begin
            chk("resp_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", n, ok ? ws_of(k) + 1 : 1);
        end
        if (!hold) begin
            cyc[k] = 1'b0; stb[k] = 1'b0;
        end
        @(posedge clk); #1;
        chk("pulse_width", {30'd0, ack[k], err[k]}, 32'd0);
    endtask

    // Write that is cut short in WAIT by dropping cyc or by reset.
    task automatic abort_wr(input int k, input logic [31:0] a, input logic [31:0] d,
                            input bit use_rst);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; adr[k] = a; sel[k] = 4'hF; wdat[k] = d;
        @(posedge clk); #1;
        if (use_rst) rst = 1'b1;
        else begin
            cyc[k] = 1'b0; stb[k] = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cyc[k] = 1'b0; stb[k] = 1'b0;
        chk("abort_no_ack", {31'd0, ack[k]}, 32'd0);
        if (use_rst) begin
            for (int j = 0; j < 3; j++) last_rd[j] = 32'd0;
            chk("rst_dat_zero", rdat[k], 32'd0);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int          idx;
        int          mode;
        bit          w;
        logic [3:0]  s;
        for (int k = 0; k < 3; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            adr[k] = 32'd0; sel[k] = 4'd0; wdat[k] = 32'd0;
            last_rd[k] = 32'd0;
            for (int i = 0; i < 1024; i++) known[k][i] = 1'b0;
        end
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_ack", {31'd0, ack[k]}, 32'd0);
            chk("reset_err", {31'd0, err[k]}, 32'd0);
            chk("reset_dat", rdat[k], 32'd0);
        end

        // One wait state: basic write/read, byte lanes, address errors.
        xfer(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        xfer(1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        chk("read_deadbeef", rdat[1], 32'hDEADBEEF);
        xfer(1, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0);
        xfer(1, 1'b1, 32'h20, 4'b1001, 32'hAABBCCDD, 1'b0);
        xfer(1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
        chk("lane_merge", rdat[1], 32'hAA2233DD);
        xfer(1, 1'b1, 32'h10, 4'h0, 32'h55555555, 1'b0);
        xfer(1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        chk("sel0_unchanged", rdat[1], 32'hDEADBEEF);
        xfer(1, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0);
        xfer(1, 1'b1, 32'h0FFC, 4'hF, 32'hCAFEF00D, 1'b0);
        xfer(1, 1'b0, 32'h0FFC, 4'hF, 32'h0, 1'b0);
        xfer(1, 1'b0, 32'h0002, 4'hF, 32'h0, 1'b0);
        chk("err_keeps_dat", rdat[1], 32'hCAFEF00D);
        known[1][4] = 1'b1; known[1][8] = 1'b1; known[1][1023] = 1'b1;

        // Three wait states, base 0x2000: abort by cyc and by reset.
        xfer(2, 1'b1, 32'h2040, 4'hF, 32'h12345678, 1'b0);
        abort_wr(2, 32'h2040, 32'hFFFFFFFF, 1'b0);
        xfer(2, 1'b0, 32'h2040, 4'hF, 32'h0, 1'b0);
        chk("abort_cyc_keeps", rdat[2], 32'h12345678);
        abort_wr(2, 32'h2040, 32'h0BADF00D, 1'b1);
        xfer(2, 1'b0, 32'h2040, 4'hF, 32'h0, 1'b0);
        chk("abort_rst_keeps", rdat[2], 32'h12345678);
        xfer(2, 1'b0, 32'h1FFC, 4'hF, 32'h0, 1'b0);
        xfer(2, 1'b1, 32'h2FFC, 4'hF, 32'h0F0F0F0F, 1'b0);
        xfer(2, 1'b0, 32'h2FFC, 4'hF, 32'h0, 1'b0);
        xfer(2, 1'b0, 32'h3000, 4'hF, 32'h0, 1'b0);
        known[2][16] = 1'b1; known[2][1023] = 1'b1;

        // Zero wait states: back-to-back reads with stb held.
        xfer(0, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0, 1'b0);
        xfer(0, 1'b1, 32'h4, 4'hF, 32'hB1B1B1B1, 1'b0);
        xfer(0, 1'b1, 32'h8, 4'hF, 32'hC2C2C2C2, 1'b0);
        xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
        xfer(0, 1'b0, 32'h4, 4'hF, 32'h0, 1'b1);
        xfer(0, 1'b0, 32'h8, 4'hF, 32'h0, 1'b0);
        chk("b2b_last", rdat[0], 32'hC2C2C2C2);
        known[0][0] = 1'b1; known[0][1] = 1'b1; known[0][2] = 1'b1;

        // Randomized traffic around the legal window edges.
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 30; t++) begin
                mode = int'($urandom_range(0, 9));
                idx  = int'($urandom_range(0, 1023));
                case (mode)
                    6:       a = base_of(k) + 32'(4 * 1023);
                    7:       a = base_of(k) + 32'(4 * 1024);
                    8:       a = base_of(k) - 32'd4;
                    9:       a = base_of(k) + 32'(4 * idx) + 32'($urandom_range(1, 3));
                    default: a = base_of(k) + 32'(4 * idx);
                endcase
                w = $urandom_range(0, 1) == 1;
                s = 4'($urandom_range(0, 15));
                if (legal(k, a)) begin
                    idx = int'((a - base_of(k)) >> 2);
                    if (!known[k][idx]) begin
                        w = 1'b1;
                        s = 4'hF;
                        known[k][idx] = 1'b1;
                    end
                end
                xfer(k, w, a, s, $urandom, 1'b0);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_data_ram_slave.md
Name: wb_data_ram_slave

Overview:
- Wishbone-style data-memory responder for the OpenMIPS minimal SOPC: the target end of the CPU data bus.
- Accepts single word/byte-lane read and write cycles from the CPU bus master.
- Inserts a configurable number of wait states, then returns a registered one-cycle ack (or err for illegal addresses).
- Replaces the zero-latency data RAM so the pipeline's stall path is exercised.

Parameters:
ADDR_WIDTH, 10, word-address bits; memory holds 2^ADDR_WIDTH 32-bit words
WAIT_STATES, 1, wait cycles inserted between request acceptance and ack (0..15)
BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wb_cyc_i  input  1  bus cycle in progress
wb_stb_i  input  1  transfer strobe
wb_we_i  input  1  1 = write, 0 = read
wb_adr_i  input  32  byte address
wb_sel_i  input  4  byte-lane enables; sel[3] = dat[31:24] (big-endian MIPS)
wb_dat_i  input  32  write data
wb_dat_o  output  32  read data, registered
wb_ack_o  output  1  transfer complete, one-cycle pulse
wb_err_o  output  1  illegal-address response, one-cycle pulse

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, wait counter=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0. Memory contents not cleared. rst has priority over every other event.
- Legal address: adr[1:0]==0, adr >= BASE_ADDR, adr < BASE_ADDR + 4*2^ADDR_WIDTH. Word index = (adr - BASE_ADDR)[ADDR_WIDTH+1:2].
- States: IDLE, WAIT, ACK, ERR.
- IDLE: at an edge with cyc&stb, latch adr/we/sel/dat.
  - Illegal address -> ERR.
  - Legal, WAIT_STATES==0 -> ACK.
  - Otherwise -> WAIT with counter=WAIT_STATES-1.
- WAIT: counter decrements each edge. At the edge where counter==0 -> ACK.
  - If cyc=0 at any WAIT edge -> IDLE; transfer aborted, no write, no ack.
- Transfer commit occurs on the edge entering ACK.
  - Write: memory bytes where sel[i]=1 take dat_i bytes (latched values); other bytes unchanged.
  - Read: wb_dat_o <= full 32-bit word regardless of sel.
- ACK: wb_ack_o=1 for exactly this cycle, then -> IDLE unconditionally. Writes leave wb_dat_o unchanged.
- ERR: wb_err_o=1 for exactly one cycle, no memory access, wb_dat_o unchanged, then -> IDLE.
- Latency from the request-sampling edge to ack high: WAIT_STATES+1 cycles. err: 1 cycle.
- Minimum spacing between transfers: WAIT_STATES+2 cycles. A request still asserted in the IDLE cycle after ACK is a new transfer.
- wb_ack_o and wb_err_o are never high together. Outputs are fully registered.
- Inputs are ignored outside IDLE, except cyc during WAIT.
- sel=4'b0000 write: legal, acked, memory unchanged.
- Highest legal word (index 2^ADDR_WIDTH-1) is accessible. The next word errors; no wrap-around.
- rst mid-WAIT: pending write discarded. Next cycle is IDLE with ack=0.

Test Plan:
- Reset with rst=1 for 10 cycles, then release -> wb_ack_o=0, wb_err_o=0, wb_dat_o=0 throughout, state IDLE.
- WAIT_STATES=1: write 32'hDEADBEEF to 0x10, sel=4'hF, then read 0x10 -> each ack rises exactly 2 cycles after the request edge and lasts 1 cycle; read returns 32'hDEADBEEF.
- Byte lanes: write 32'h11223344 to 0x20 with sel=4'hF, then write 32'hAABBCCDD with sel=4'b1001, then read 0x20 -> 32'hAA2233DD.
- Errors with ADDR_WIDTH=10, BASE=0:
  - read 0x1000 -> wb_err_o pulses 1 cycle after request, no ack.
  - read 0x0FFC -> normal ack.
  - read 0x0002 -> err; wb_dat_o unchanged.
- Abort/reset with WAIT_STATES=3:
  - drop cyc one cycle after a write to 0x40 -> no ack; later read of 0x40 returns prior contents.
  - assert rst during WAIT of a second write -> same result.
- Back-to-back with WAIT_STATES=0 and stb held high for 3 reads of 0x0, 0x4, 0x8 (addr advanced on each ack) -> acks every 2 cycles with the correct data.
